fifo_ctrl: RTL and testbench
============================

FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, number of FIFO entries; the design is fixed at power-of-two depth 8.
REQ-002 Port clk, input, 1, single clock; all registers update on the rising edge.
REQ-003 Port reset, input, 1, asynchronous active-high reset.
REQ-004 Port wr_en, input, 1, write request for the current cycle.
REQ-005 Port rd_en, input, 1, read request for the current cycle.
REQ-006 Port state, output, 3, registered operation state, consumed by the FIFO output-flag logic.
REQ-007 Port data_count, output, 4, registered occupancy, 0..8.
REQ-008 Port head, output, 3, registered read pointer into the 8-entry register file.
REQ-009 Port tail, output, 3, registered write pointer into the 8-entry register file.
REQ-010 Port we, output, 1, combinational register-file write strobe for the current cycle.
REQ-011 Port re, output, 1, combinational register-file read strobe for the current cycle.

Function
REQ-012 State encoding SHALL be: INIT=000, NO_OP=001, WRITE=010, READ=011, WR_ERROR=100, RD_ERROR=101; 110 and 111 are never produced.
REQ-013 Next state SHALL be decided from wr_en, rd_en and the current data_count: wr_en=1 and rd_en=0 with data_count<8 gives WRITE; with data_count=8 it gives WR_ERROR.
REQ-014 rd_en=1 and wr_en=0 with data_count>0 SHALL give READ; with data_count=0 it gives RD_ERROR.
REQ-015 wr_en=rd_en (both 0 or both 1) SHALL give NO_OP; a simultaneous request is ignored, and pointers and count hold.
REQ-016 Transitions SHALL be legal from every state, including INIT and both error states; an error state lasts exactly one cycle unless the request repeats.
REQ-017 we SHALL equal 1 exactly when the next state is WRITE; re SHALL equal 1 exactly when the next state is READ; both SHALL be 0 during reset.
REQ-018 On the edge that enters WRITE, tail SHALL increment modulo 8 (7 wraps to 0) and data_count SHALL increment by 1.
REQ-019 On the edge that enters READ, head SHALL increment modulo 8 and data_count SHALL decrement by 1.
REQ-020 In NO_OP, WR_ERROR and RD_ERROR, head, tail and data_count SHALL hold.
REQ-021 data_count SHALL never leave 0..8; tail-head modulo 8 SHALL equal data_count modulo 8 at all times.
REQ-022 Latency: state, data_count and pointers SHALL reflect a request one clock edge after it is sampled; we and re have zero latency.
REQ-023 With data_count=8, head SHALL equal tail; with data_count=0, head SHALL also equal tail; full and empty are distinguished by data_count only.

Reset
REQ-024 Asserting reset SHALL immediately force state=INIT, data_count=0, head=0 and tail=0, independent of clk.
REQ-025 Reset asserted mid-operation SHALL discard occupancy without completing the in-flight request.
REQ-026 The first edge after reset deassertion SHALL evaluate the inputs normally from INIT.

Structure
REQ-027 The state encodings and the depth constant SHALL reside in a shared fifo package or include, used by both this block and the output-flag logic.
REQ-028 The next-state decode SHALL be a combinational sub-module, fifo_ns, with inputs wr_en, rd_en and data_count and output next_state; fifo_ctrl holds the registers, counter and pointers.
REQ-029 No latches SHALL be inferred; unused encodings in every case statement SHALL default to x.

Verification
REQ-030 Reset then idle 3 cycles -> state=INIT then NO_OP; count=0; head=tail=0; we=re=0.
REQ-031 Nine consecutive writes from empty -> count reaches 8 on write 8, tail wraps to 0, state=WRITE x8, then WR_ERROR on write 9 with count 8 held and we=0.
REQ-032 Full FIFO, nine reads -> count 8→0, head wraps to 0, state READ x8, then RD_ERROR with count 0 held and re=0.
REQ-033 count=3, wr_en=rd_en=1 for 2 cycles -> state=NO_OP, count=3, pointers unchanged, we=re=0.
REQ-034 count=5 with head=2 and tail=7, single write -> tail=0 and count=6; single read -> head=3 and count=5.
REQ-035 Assert reset between clock edges while count=4 -> all outputs return to their reset values before the next edge; a subsequent read gives RD_ERROR.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: depth, pointer/count widths and the operation-state encoding.
// Used by the FIFO controller and by the output-flag logic.
package fifo_pkg;

  localparam int unsigned FifoDepth = 8;
  localparam int unsigned PtrW      = 3;
  localparam int unsigned CntW      = 4;

  typedef enum logic [2:0] {
    StInit    = 3'b000,
    StNoOp    = 3'b001,
    StWrite   = 3'b010,
    StRead    = 3'b011,
    StWrError = 3'b100,
    StRdError = 3'b101
  } state_e;

endpackage

// File: rtl/fifo_ns.sv
// Combinational next-state decode for the FIFO controller.
// The decision depends only on the request pair and the current occupancy.
module fifo_ns
  import fifo_pkg::*;
#(
  parameter int unsigned Depth = FifoDepth
) (
  input  logic            wr_en,
  input  logic            rd_en,
  input  logic [CntW-1:0] data_count,
  output logic [2:0]      next_state
);

  logic full;
  logic empty;

  assign full  = (data_count == CntW'(Depth));
  assign empty = (data_count == '0);

  always_comb begin
    next_state = StNoOp;
    unique case ({wr_en, rd_en})
      2'b10:   next_state = full  ? StWrError : StWrite;
      2'b01:   next_state = empty ? StRdError : StRead;
      // Simultaneous requests are ignored.
      2'b00,
      2'b11:   next_state = StNoOp;
      default: next_state = 'x;
    endcase
  end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller: state register, occupancy counter and read/write pointers
// for an 8-entry register file, with zero-latency write/read strobes.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = FifoDepth
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       rd_en,
  output logic [2:0] state,
  output logic [3:0] data_count,
  output logic [2:0] head,
  output logic [2:0] tail,
  output logic       we,
  output logic       re
);

  state_e            state_q, state_d;
  logic [2:0]        ns_raw;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;

  fifo_ns #(
    .Depth(DEPTH)
  ) u_ns (
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .data_count(count_q),
    .next_state(ns_raw)
  );

  assign state_d = state_e'(ns_raw);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case (state_d)
      // Pointers wrap naturally at the 3-bit width.
      StWrite: begin
        tail_d  = tail_q + 3'd1;
        count_d = count_q + 4'd1;
      end
      StRead: begin
        head_d  = head_q + 3'd1;
        count_d = count_q - 4'd1;
      end
      StInit, StNoOp, StWrError, StRdError: ;
      default: begin
        head_d  = 'x;
        tail_d  = 'x;
        count_d = 'x;
      end
    endcase
  end

  // Strobes are gated by reset so the register file is never touched while resetting.
  assign we = (state_d == StWrite) && !reset;
  assign re = (state_d == StRead) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StInit;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign state      = state_q;
  assign data_count = count_q;
  assign head       = head_q;
  assign tail       = tail_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: a vector table followed by model-driven corner sequences,
// with registered outputs checked through an expected-value queue.
module tb_fifo_ctrl;

  localparam logic [2:0] SInit = 3'd0, SNoOp = 3'd1, SWr = 3'd2, SRd = 3'd3;
  localparam logic [2:0] SWrErr = 3'd4, SRdErr = 3'd5;

  logic       clk, reset, wr_en, rd_en;
  logic [2:0] state, head, tail;
  logic [3:0] data_count;
  logic       we, re;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       wr;
    logic       rd;
    logic [2:0] st;
    logic [3:0] cnt;
    logic [2:0] hd;
    logic [2:0] tl;
    logic       we_x;
    logic       re_x;
  } vec_t;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] cnt;
    logic [2:0] hd;
    logic [2:0] tl;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];

  int m_cnt, m_head, m_tail;

  fifo_ctrl #(
    .DEPTH(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .state     (state),
    .data_count(data_count),
    .head      (head),
    .tail      (tail),
    .we        (we),
    .re        (re)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({tag, "_state"}, int'(state), int'(e.st));
      check({tag, "_count"}, int'(data_count), int'(e.cnt));
      check({tag, "_head"}, int'(head), int'(e.hd));
      check({tag, "_tail"}, int'(tail), int'(e.tl));
    end
  endtask

  // Drive one request at the falling edge, check strobes, then check registers after the edge.
  task automatic apply(input string tag, input logic wr, input logic rd, input exp_t e,
                       input logic we_x, input logic re_x);
    @(negedge clk);
    wr_en = wr;
    rd_en = rd;
    #1;
    check({tag, "_we"}, int'(we), int'(we_x));
    check({tag, "_re"}, int'(re), int'(re_x));
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_compare(tag);
  endtask

  task automatic step(input string tag, input logic wr, input logic rd);
    exp_t e;
    logic we_x, re_x;
    we_x = 1'b0;
    re_x = 1'b0;
    if (wr && !rd) begin
      if (m_cnt < 8) begin
        e.st = SWr; we_x = 1'b1; m_tail = (m_tail + 1) % 8; m_cnt++;
      end else begin
        e.st = SWrErr;
      end
    end else if (rd && !wr) begin
      if (m_cnt > 0) begin
        e.st = SRd; re_x = 1'b1; m_head = (m_head + 1) % 8; m_cnt--;
      end else begin
        e.st = SRdErr;
      end
    end else begin
      e.st = SNoOp;
    end
    e.cnt = 4'(m_cnt);
    e.hd  = 3'(m_head);
    e.tl  = 3'(m_tail);
    apply(tag, wr, rd, e, we_x, re_x);
  endtask

  // Assert reset between clock edges and check the outputs clear before any edge.
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    #1;
    check({tag, "_state"}, int'(state), int'(SInit));
    check({tag, "_count"}, int'(data_count), 0);
    check({tag, "_head"}, int'(head), 0);
    check({tag, "_tail"}, int'(tail), 0);
    check({tag, "_we"}, int'(we), 0);
    @(negedge clk);
    reset = 1'b0;
    m_cnt  = 0;
    m_head = 0;
    m_tail = 0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, SNoOp,  4'd0, 3'd0, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, SRdErr, 4'd0, 3'd0, 3'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, SWr,    4'd1, 3'd0, 3'd1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, SWr,    4'd2, 3'd0, 3'd2, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, SNoOp,  4'd2, 3'd0, 3'd2, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, SRd,    4'd1, 3'd1, 3'd2, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, SWr,    4'd2, 3'd1, 3'd3, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, SRd,    4'd1, 3'd2, 3'd3, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, SRd,    4'd0, 3'd3, 3'd3, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, SRdErr, 4'd0, 3'd3, 3'd3, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, SNoOp,  4'd0, 3'd3, 3'd3, 1'b0, 1'b0};

    // Reset with a write request pending: strobes must stay low.
    reset = 1'b1;
    wr_en = 1'b1;
    rd_en = 1'b0;
    #3;
    check("por_state", int'(state), int'(SInit));
    check("por_count", int'(data_count), 0);
    check("por_head", int'(head), 0);
    check("por_tail", int'(tail), 0);
    check("por_we", int'(we), 0);
    check("por_re", int'(re), 0);
    @(negedge clk);
    wr_en = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      exp_t e;
      e.st  = vecs[i].st;
      e.cnt = vecs[i].cnt;
      e.hd  = vecs[i].hd;
      e.tl  = vecs[i].tl;
      apply($sformatf("vec%0d", i), vecs[i].wr, vecs[i].rd, e, vecs[i].we_x, vecs[i].re_x);
    end

    // Fill to full, wrap tail, then overflow attempt.
    do_reset("rst_a");
    for (int i = 0; i < 9; i++) step($sformatf("fill%0d", i), 1'b1, 1'b0);
    check("full_tail_wrap", int'(tail), 0);
    check("full_count", int'(data_count), 8);

    // Drain to empty, wrap head, then underflow attempt.
    for (int i = 0; i < 9; i++) step($sformatf("drain%0d", i), 1'b0, 1'b1);
    check("empty_head_wrap", int'(head), 0);

    // Simultaneous requests hold everything.
    do_reset("rst_b");
    for (int i = 0; i < 3; i++) step($sformatf("pre_both%0d", i), 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step($sformatf("both%0d", i), 1'b1, 1'b1);
    check("both_count", int'(data_count), 3);

    // Pointer wrap with head=2, tail=7, count=5.
    do_reset("rst_c");
    for (int i = 0; i < 7; i++) step($sformatf("wr7_%0d", i), 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step($sformatf("rd2_%0d", i), 1'b0, 1'b1);
    check("mid_head", int'(head), 2);
    check("mid_tail", int'(tail), 7);
    step("wrap_wr", 1'b1, 1'b0);
    check("wrap_wr_tail", int'(tail), 0);
    check("wrap_wr_count", int'(data_count), 6);
    step("wrap_rd", 1'b0, 1'b1);
    check("wrap_rd_head", int'(head), 3);
    check("wrap_rd_count", int'(data_count), 5);

    // Mid-operation reset discards occupancy.
    do_reset("rst_d");
    for (int i = 0; i < 4; i++) step($sformatf("pre_rst%0d", i), 1'b1, 1'b0);
    do_reset("rst_mid");
    step("post_rst_rd", 1'b0, 1'b1);
    check("post_rst_state", int'(state), int'(SRdErr));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
